rle_izigzag_decoder: RTL

// - Decode side of the JPEG pipeline, one colour channel; instantiate once each for Y, Cr and Cb.
// - Takes the DPCM DC word and the RLE AC symbol stream.
// - Rebuilds one 8x8 block of quantized coefficients in natural (raster) order.
// - Presents the block as a 640-bit word in the quantizer's format, for the dequantizer / IDCT.

---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/rle_izigzag_decoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG decode definitions: field widths, RLE special symbols,
// decoder state encoding and the zigzag-to-raster scan table.
package jpeg_pkg;

  localparam int COEF_W = 10;
  localparam int RUN_W  = 4;
  localparam int NCOEF  = 64;
  localparam int SYM_W  = RUN_W + COEF_W;
  localparam int POS_W  = 7;

  localparam logic [SYM_W-1:0] EOB_SYM = '0;
  localparam logic [SYM_W-1:0] ZRL_SYM = {4'hF, 10'h000};

  typedef enum logic [1:0] {S_DC, S_AC, S_OUT} state_e;

  // zigzag scan index -> raster index (row*8+col), same table as the encoder
  localparam logic [5:0] ZZ2NAT [NCOEF] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/rle_izigzag_decoder.sv
// RLE + inverse zigzag decoder for one colour channel. Rebuilds an 8x8 block
// of quantized coefficients in raster order from a DC word and AC RLE symbols.
// Optional macro IZZ_DC_ACCUM_EN: dc_in is a DPCM difference accumulated into
// a persistent predictor; otherwise dc_in is the absolute DC value.
module rle_izigzag_decoder
  import jpeg_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COEF_W-1:0]       dc_in,
  input  logic                    dc_valid,
  output logic                    dc_ready,
  input  logic [SYM_W-1:0]        rle_in,
  input  logic                    rle_valid,
  output logic                    rle_ready,
  output logic [NCOEF*COEF_W-1:0] block_out,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    error
);

  state_e                         state_q;
  logic [POS_W-1:0]               pos_q;
  logic [NCOEF-1:0][COEF_W-1:0]   buf_q;
  logic                           err_q;
  logic                           dc_rdy_q;
  logic                           rle_rdy_q;
  logic                           blk_vld_q;

  logic [RUN_W-1:0]               run;
  logic [COEF_W-1:0]              level;
  logic [POS_W-1:0]               tgt;
  logic [POS_W-1:0]               zrl_pos;
  logic                           is_eob;
  logic                           is_zrl;
  logic                           ovf;
  logic                           ac_done;
  logic [COEF_W-1:0]              dc_val;

  assign run     = rle_in[SYM_W-1:COEF_W];
  assign level   = rle_in[COEF_W-1:0];
  assign tgt     = pos_q + POS_W'(run);
  assign zrl_pos = pos_q + 7'd16;
  assign is_eob  = (rle_in == EOB_SYM);
  assign is_zrl  = (rle_in == ZRL_SYM);
  // a plain symbol landing beyond coefficient 63 is dropped and flagged
  assign ovf     = !is_eob && !is_zrl && (tgt > 7'd63);
  // EOB, a ZRL running off the end, the write to zz63, or an overflow all close the block
  assign ac_done = is_eob || (is_zrl ? (zrl_pos > 7'd63) : (tgt >= 7'd63));

`ifdef IZZ_DC_ACCUM_EN
  logic [COEF_W-1:0] pred_q;

  assign dc_val = pred_q + dc_in;

  // DC predictor follows every reconstructed DC and survives block boundaries
  always_ff @(posedge clk) begin
    if (reset)
      pred_q <= '0;
    else if (state_q == S_DC && dc_valid && dc_rdy_q)
      pred_q <= dc_val;
  end
`else
  assign dc_val = dc_in;
`endif

  // block FSM: DC capture, AC symbol placement, output hold; handshake flags registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_DC;
      pos_q     <= 7'd1;
      buf_q     <= '0;
      err_q     <= 1'b0;
      dc_rdy_q  <= 1'b0;
      rle_rdy_q <= 1'b0;
      blk_vld_q <= 1'b0;
    end else begin
      case (state_q)
        S_DC: begin
          if (dc_valid && dc_rdy_q) begin
            buf_q[0]  <= dc_val;
            pos_q     <= 7'd1;
            state_q   <= S_AC;
            dc_rdy_q  <= 1'b0;
            rle_rdy_q <= 1'b1;
          end else begin
            dc_rdy_q  <= 1'b1;
          end
        end
        S_AC: begin
          if (rle_valid && rle_rdy_q) begin
            if (is_zrl)
              pos_q <= zrl_pos;
            else if (!is_eob && !ovf) begin
              buf_q[ZZ2NAT[tgt[5:0]]] <= level;
              pos_q <= tgt + 7'd1;
            end
            if (ovf)
              err_q <= 1'b1;
            if (ac_done) begin
              state_q   <= S_OUT;
              rle_rdy_q <= 1'b0;
              blk_vld_q <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (block_ready && blk_vld_q) begin
            buf_q     <= '0;
            state_q   <= S_DC;
            blk_vld_q <= 1'b0;
            dc_rdy_q  <= 1'b1;
          end
        end
        default: state_q <= S_DC;
      endcase
    end
  end

  assign dc_ready    = dc_rdy_q;
  assign rle_ready   = rle_rdy_q;
  assign block_out   = buf_q;
  assign block_valid = blk_vld_q;
  assign error       = err_q;

endmodule
